// File: rtl/key_led_pkg.sv
// Shared constants for the key-driven LED pattern controller.
package key_led_pkg;

    localparam int unsigned MODE_W  = 2;
    localparam int unsigned SPEED_W = 2;
    localparam int unsigned N_KEY   = 2;

    localparam logic [MODE_W-1:0] MODE_OFF   = 2'd0;
    localparam logic [MODE_W-1:0] MODE_BLINK = 2'd1;
    localparam logic [MODE_W-1:0] MODE_ALT   = 2'd2;
    localparam logic [MODE_W-1:0] MODE_RUN   = 2'd3;

endpackage

// File: rtl/key_debounce.sv
// Synchroniser, debounce filter and press-edge pulse for one active-low key.
// Ports:
//   sys_clk  - system clock
//   sys_rst  - synchronous active-high reset
//   key_raw  - raw active-low push-button, asynchronous to sys_clk
//   press    - one-cycle pulse on an accepted 1->0 (press) transition, registered
module key_debounce #(
    parameter int unsigned DEB_CNT = 1000000
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic key_raw,
    output logic press
);

    localparam int unsigned CNT_W = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;

    logic             sync1;
    logic             sync2;
    logic             sync_prev;
    logic             key_state;
    logic [CNT_W-1:0] deb_cnt;
    logic             stable_diff_c;
    logic             accept_c;

    // Count only while the level differs from the accepted state and holds still.
    assign stable_diff_c = (sync2 != key_state) && (sync2 == sync_prev);
    assign accept_c      = stable_diff_c && (deb_cnt == CNT_W'(DEB_CNT - 1));

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            sync_prev <= 1'b1;
            key_state <= 1'b1;
            deb_cnt   <= '0;
            press     <= 1'b0;
        end else begin
            sync1     <= key_raw;
            sync2     <= sync1;
            sync_prev <= sync2;
            press     <= accept_c && !sync2;
            if (!stable_diff_c) begin
                deb_cnt <= '0;
            end else if (accept_c) begin
                deb_cnt   <= '0;
                key_state <= sync2;
            end else begin
                deb_cnt <= deb_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/key_led_ctrl.sv
// Key-driven LED pattern controller: key[0] steps the pattern mode, key[1]
// steps the pattern rate; patterns are OFF, BLINK, ALT and RUN.
// Ports:
//   sys_clk  - system clock
//   sys_rst  - synchronous active-high reset
//   key      - raw active-low push-buttons, key[0]=mode, key[1]=speed
//   led      - LED drive, 1 = on, registered
//   mode_o   - current pattern mode, registered
//   speed_o  - current speed index, registered
module key_led_ctrl
    import key_led_pkg::*;
#(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned DEB_CNT  = 1000000,
    parameter int unsigned TICK_CNT = 25000000
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic [N_KEY-1:0]   key,
    output logic [N_LED-1:0]   led,
    output logic [MODE_W-1:0]  mode_o,
    output logic [SPEED_W-1:0] speed_o
);

    localparam int unsigned TICK_W = $clog2(TICK_CNT);
    localparam int unsigned IDX_W  = $clog2(N_LED);

    logic [N_KEY-1:0]   press;
    logic [TICK_W-1:0]  tick_cnt;
    logic               flag;
    logic [IDX_W-1:0]   run_idx;
    logic [TICK_W-1:0]  period_last_c;
    logic               tick_c;

    logic [MODE_W-1:0]  mode_n;
    logic [SPEED_W-1:0] speed_n;
    logic [TICK_W-1:0]  tick_n;
    logic               flag_n;
    logic [IDX_W-1:0]   idx_n;
    logic [N_LED-1:0]   led_n;

    // One debounce channel per key.
    for (genvar g = 0; g < int'(N_KEY); g++) begin : g_key
        key_debounce #(
            .DEB_CNT (DEB_CNT)
        ) u_deb (
            .sys_clk (sys_clk),
            .sys_rst (sys_rst),
            .key_raw (key[g]),
            .press   (press[g])
        );
    end

    // Step period halves with each speed index.
    assign period_last_c = TICK_W'((TICK_CNT >> speed_o) - 1);
    assign tick_c        = (tick_cnt == period_last_c);

    // Next-state for mode/speed/tick state and LED decode of the current state.
    always_comb begin
        mode_n  = mode_o;
        speed_n = speed_o;
        tick_n  = tick_cnt + TICK_W'(1);
        flag_n  = flag;
        idx_n   = run_idx;
        led_n   = '0;

        if (press[0]) mode_n  = mode_o + MODE_W'(1);
        if (press[1]) speed_n = speed_o + SPEED_W'(1);

        // A mode or speed change restarts the pattern and wins over a tick.
        if (|press) begin
            tick_n = '0;
            flag_n = 1'b0;
            idx_n  = '0;
        end else if (tick_c) begin
            tick_n = '0;
            flag_n = ~flag;
            idx_n  = (run_idx == IDX_W'(N_LED - 1)) ? '0 : run_idx + IDX_W'(1);
        end

        case (mode_o)
            MODE_BLINK: led_n = {N_LED{flag}};
            MODE_ALT: begin
                for (int i = 0; i < int'(N_LED); i++) begin
                    led_n[i] = ((i % 2) == 0) ? flag : ~flag;
                end
            end
            MODE_RUN: led_n = N_LED'(1) << run_idx;
            default:  led_n = '0;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            mode_o   <= MODE_OFF;
            speed_o  <= '0;
            tick_cnt <= '0;
            flag     <= 1'b0;
            run_idx  <= '0;
            led      <= '0;
        end else begin
            mode_o   <= mode_n;
            speed_o  <= speed_n;
            tick_cnt <= tick_n;
            flag     <= flag_n;
            run_idx  <= idx_n;
            led      <= led_n;
        end
    end

endmodule

// File: tb/tb_key_led_ctrl.sv
// Self-checking bench for key_led_ctrl with DEB_CNT=4, TICK_CNT=16, N_LED=4.
module tb_key_led_ctrl;

    localparam int N_LED = 4;
    localparam int DEB   = 4;
    localparam int TICK  = 16;
    localparam int WAIT_LIMIT = 200;

    logic             sys_clk = 1'b0;
    logic             sys_rst = 1'b1;
    logic [1:0]       key     = 2'b11;
    logic [N_LED-1:0] led;
    logic [1:0]       mode_o;
    logic [1:0]       speed_o;

    always #5 sys_clk = ~sys_clk;

    key_led_ctrl #(
        .N_LED    (N_LED),
        .DEB_CNT  (DEB),
        .TICK_CNT (TICK)
    ) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .key     (key),
        .led     (led),
        .mode_o  (mode_o),
        .speed_o (speed_o)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Keys: a level is accepted once DEB+1 consecutive raw samples agree;
    // the resulting mode/speed step lands 3 edges after that last sample.
    // Pattern: derived from cycles elapsed since the last restart.
    bit               model_ok = 0;
    int               m_mode, m_speed, m_elapsed;
    logic [N_LED-1:0] m_led;
    int               run_val [2];
    int               run_len [2];
    int               acc     [2];
    int               pipe    [2][3];
    int               newp    [2];
    int               apply   [2];

    function automatic logic [N_LED-1:0] pattern(input int mode, input int speed, input int elapsed);
        logic [N_LED-1:0] r;
        int p, steps, fl, ix;
        p     = TICK >> speed;
        steps = elapsed / p;
        fl    = steps % 2;
        ix    = steps % N_LED;
        r     = '0;
        case (mode)
            1: r = {N_LED{fl == 1}};
            2: for (int i = 0; i < N_LED; i++) r[i] = ((i % 2) == 0) ? (fl == 1) : (fl == 0);
            3: r[ix] = 1'b1;
            default: r = '0;
        endcase
        return r;
    endfunction

    always @(posedge sys_clk) begin
        if (sys_rst) begin
            m_mode = 0; m_speed = 0; m_elapsed = 0; m_led = '0;
            for (int k = 0; k < 2; k++) begin
                run_val[k] = 1; run_len[k] = DEB + 1; acc[k] = 1;
                for (int s = 0; s < 3; s++) pipe[k][s] = 0;
            end
            model_ok = 1;
        end else begin
            m_led = pattern(m_mode, m_speed, m_elapsed);
            for (int k = 0; k < 2; k++) begin
                newp[k] = 0;
                if (int'(key[k]) == run_val[k]) begin
                    if (run_len[k] < DEB + 1) run_len[k]++;
                end else begin
                    run_val[k] = int'(key[k]);
                    run_len[k] = 1;
                end
                if (run_len[k] >= DEB + 1 && run_val[k] != acc[k]) begin
                    acc[k] = run_val[k];
                    if (run_val[k] == 0) newp[k] = 1;
                end
                apply[k]   = pipe[k][2];
                pipe[k][2] = pipe[k][1];
                pipe[k][1] = pipe[k][0];
                pipe[k][0] = newp[k];
            end
            if (apply[0] != 0) m_mode  = (m_mode + 1) % 4;
            if (apply[1] != 0) m_speed = (m_speed + 1) % 4;
            if (apply[0] != 0 || apply[1] != 0) m_elapsed = 0;
            else m_elapsed++;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge sys_clk) begin
        if (model_ok) begin
            check("model_led",   int'(led),     int'(m_led));
            check("model_mode",  int'(mode_o),  m_mode);
            check("model_speed", int'(speed_o), m_speed);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic press(input logic [1:0] mask);
        key = ~mask;
        repeat (10) @(negedge sys_clk);
        key = 2'b11;
        repeat (12) @(negedge sys_clk);
    endtask

    task automatic wait_change(output int cycles, output logic [N_LED-1:0] val);
        logic [N_LED-1:0] start;
        start  = led;
        cycles = 0;
        while (led == start && cycles < WAIT_LIMIT) begin
            @(negedge sys_clk);
            cycles++;
        end
        if (cycles >= WAIT_LIMIT) check("led_change_timeout", cycles, 0);
        val = led;
    endtask

    int               cyc;
    logic [N_LED-1:0] v;
    logic [N_LED-1:0] run_seq [4];
    int               per_exp [4];

    initial begin
        run_seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        per_exp = '{8, 4, 2, 16};

        // Reset
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst_led",   int'(led),     0);
        check("rst_mode",  int'(mode_o),  0);
        check("rst_speed", int'(speed_o), 0);

        // Bounce shorter than the filter, then a real press
        key = 2'b10;
        repeat (3) @(negedge sys_clk);
        key = 2'b11;
        repeat (8) @(negedge sys_clk);
        check("bounce_no_step", int'(mode_o), 0);
        press(2'b01);
        check("press_mode1", int'(mode_o), 1);

        // BLINK at speed 0
        check("blink_start", int'(led), 4'b0000);
        wait_change(cyc, v);
        check("blink_on", int'(v), 4'b1111);
        wait_change(cyc, v);
        check("blink_off", int'(v), 4'b0000);
        check("blink_period", cyc, 16);

        // RUN
        press(2'b01);
        press(2'b01);
        check("run_mode", int'(mode_o), 3);
        check("run_start", int'(led), 4'b0001);
        for (int i = 0; i < 4; i++) begin
            wait_change(cyc, v);
            check("run_step", int'(v), int'(run_seq[i]));
        end
        check("run_period", cyc, 16);

        // Back round to ALT
        repeat (3) press(2'b01);
        check("alt_mode", int'(mode_o), 2);
        check("alt_start", int'(led), 4'b1010);
        wait_change(cyc, v);
        check("alt_a", int'(v), 4'b0101);
        wait_change(cyc, v);
        check("alt_b", int'(v), 4'b1010);
        check("alt_period", cyc, 16);

        // Speed stepping in BLINK
        repeat (3) press(2'b01);
        check("spd_mode", int'(mode_o), 1);
        for (int i = 0; i < 4; i++) begin
            press(2'b10);
            check("spd_index", int'(speed_o), (i + 1) % 4);
            wait_change(cyc, v);
            wait_change(cyc, v);
            check("spd_period", cyc, per_exp[i]);
        end

        // Both keys together in RUN
        press(2'b01);
        press(2'b01);
        check("both_pre_mode", int'(mode_o), 3);
        press(2'b11);
        check("both_mode",  int'(mode_o),  0);
        check("both_speed", int'(speed_o), 1);
        check("both_led",   int'(led),     4'b0000);

        // Reset mid-activity
        press(2'b01);
        press(2'b10);
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        sys_rst = 1'b0;
        check("rst2_led",   int'(led),     0);
        check("rst2_mode",  int'(mode_o),  0);
        check("rst2_speed", int'(speed_o), 0);
        repeat (20) @(negedge sys_clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
